vga_text_scan: RTL and testbench



---
 rtl/vga_text_scan_pkg.sv | 50 +++++
 rtl/font_rom.sv | 29 ++
 rtl/vga_text_scan.sv | 174 +++++++++++++++++
 tb/tb_vga_text_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_text_scan_pkg.sv
// Shared timing defaults, text-grid constants, pipeline control type and the
// built-in font generator for the VGA text scanner.
package vga_text_scan_pkg;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOTAL = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  localparam int COLS   = 80;
  localparam int ROWS   = 48;
  localparam int CELL_W = 8;
  localparam int CELL_H = 10;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 10;

  typedef logic [ADDR_W-1:0] font_addr_t;

  // Per-pixel control carried alongside the RAM/font pipeline.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] hx;
    logic       cur;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, hx: 3'd0, cur: 1'b0};

  // Glyph contents: code 0 is blank, slot rows 10..15 are blank, everything
  // else is a fixed scramble of code and row (code 0x1C row 0 = 0xA5).
  function automatic logic [7:0] font_glyph(input font_addr_t a);
    logic [7:0] code;
    logic [3:0] line;
    code = a[11:4];
    line = a[3:0];
    if (code == 8'h00 || line >= 4'(CELL_H)) begin
      return 8'h00;
    end
    return code ^ (8'(line) * 8'h13) ^ 8'hB9;
  endfunction

endpackage

// File: rtl/font_rom.sv
// Synchronous 4096x8 font ROM indexed by {scan code, glyph row}; the
// registered output is the t+2 stage of the text pipeline.
module font_rom
  import vga_text_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  font_addr_t addr,
  output logic [7:0] data
);

  logic [7:0] data_q;
  logic [7:0] data_d;

  always_comb begin
    data_d = font_glyph(addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/vga_text_scan.sv
// 640x480 VGA text scanner: counters -> RAM address -> font ROM -> pixel,
// three cycles of latency. Define CURSOR_EN to add a blinking inverse cursor.
module vga_text_scan
  import vga_text_scan_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [7:0]        ram_q,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              pixel,
  output logic              frame_tick
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam int               PIPE     = 2;

  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  v_q, v_d;
  logic [3:0]        line_q, line_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [3:0]        line1_q, line1_d;
  logic              frame_tick_q, frame_tick_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic              pixel_q, pixel_d;
  ctl_t              ctl_q [PIPE];
  ctl_t              ctl_d [PIPE];
  ctl_t              ctl_now;
  logic              h_wrap, v_wrap, visible, cur_now;
  logic [7:0]        font_byte;

  // Text position advances incrementally: row_base steps by COLS per cell row.
  always_comb begin
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == V_LAST);
    h_d        = h_wrap ? '0 : h_q + 1'b1;
    v_d        = v_q;
    line_d     = line_q;
    row_base_d = row_base_q;
    if (h_wrap) begin
      if (v_wrap) begin
        v_d        = '0;
        line_d     = '0;
        row_base_d = '0;
      end else begin
        v_d = v_q + 1'b1;
        if (v_q < V_VIS_C) begin
          if (line_q == 4'(CELL_H - 1)) begin
            line_d     = '0;
            row_base_d = row_base_q + ADDR_W'(COLS);
          end else begin
            line_d = line_q + 1'b1;
          end
        end
      end
    end
    frame_tick_d = h_wrap && v_wrap;
  end

  always_comb begin
    visible   = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    read_addr = visible ? row_base_q + {5'd0, h_q[9:3]} : '0;
  end

`ifdef CURSOR_EN
  logic [4:0] blink_q, blink_d;

  always_comb begin
    blink_d = frame_tick_q ? blink_q + 1'b1 : blink_q;
    cur_now = (read_addr == cursor_addr) && blink_q[4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  logic unused_cursor;

  always_comb begin
    unused_cursor = ^cursor_addr;
    cur_now       = 1'b0;
  end
`endif

  always_comb begin
    ctl_now.hs  = !((h_q >= HS_BEG) && (h_q < HS_END));
    ctl_now.vs  = !((v_q >= VS_BEG) && (v_q < VS_END));
    ctl_now.de  = visible;
    ctl_now.hx  = h_q[2:0];
    ctl_now.cur = cur_now;
    ctl_d[0]    = ctl_now;
    for (int i = 1; i < PIPE; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
    line1_d  = line_q;
    hsync_d  = ctl_q[PIPE-1].hs;
    vsync_d  = ctl_q[PIPE-1].vs;
    de_d     = ctl_q[PIPE-1].de;
    pixel_d  = ctl_q[PIPE-1].de &&
               (font_byte[3'd7 - ctl_q[PIPE-1].hx] ^ ctl_q[PIPE-1].cur);
  end

  // Glyph row must match the cell whose code arrives on ram_q one cycle later.
  font_rom u_font_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  ({ram_q, line1_q}),
    .data  (font_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q          <= '0;
      v_q          <= '0;
      line_q       <= '0;
      row_base_q   <= '0;
      line1_q      <= '0;
      frame_tick_q <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      pixel_q      <= 1'b0;
      for (int i = 0; i < PIPE; i++) begin
        ctl_q[i] <= CTL_RST;
      end
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      line_q       <= line_d;
      row_base_q   <= row_base_d;
      line1_q      <= line1_d;
      frame_tick_q <= frame_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      pixel_q      <= pixel_d;
      for (int i = 0; i < PIPE; i++) begin
        ctl_q[i] <= ctl_d[i];
      end
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign pixel      = pixel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_text_scan.sv
// Bench for vga_text_scan on a shrunken raster (40x24 total, 4x2 cells) so that
// many frames fit in a short run; outputs are predicted from raster position.
module tb_vga_text_scan;

  localparam int HV = 32, HF = 2, HS = 4, HB = 2;
  localparam int VV = 20, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] read_addr;
  logic [7:0]  ram_q;
  logic [11:0] cursor_addr;
  logic        hsync, vsync, de, pixel, frame_tick;

  logic [7:0]  ram [4096];
  int          t = 0;
  bit          started = 1'b0;
  bit          mid_done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  vga_text_scan #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_addr   (read_addr),
    .ram_q       (ram_q),
    .cursor_addr (cursor_addr),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .pixel       (pixel),
    .frame_tick  (frame_tick)
  );

  always @(posedge clk) ram_q <= ram[read_addr];

  // t = cycles since the last clock edge that saw reset (counters at (0,0)).
  always @(posedge clk) begin
    if (!rst_n) begin
      t       <= 0;
      started <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  function automatic logic [7:0] glyph(input logic [7:0] code, input int row);
    if (code == 8'h00 || row >= 10) return 8'h00;
    return code ^ 8'(row * 19) ^ 8'hB9;
  endfunction

  function automatic logic [11:0] exp_addr(input int tt);
    int p, h, v;
    p = tt % FT;
    h = p % HT;
    v = p / HT;
    if (h < HV && v < VV) return 12'((v / 10) * 80 + h / 8);
    return 12'd0;
  endfunction

  task automatic exp_out(input int tt, output logic ehs, output logic evs,
                         output logic ede, output logic epx);
    int s, p, h, v, blink;
    logic [7:0] g;
    logic [11:0] a;
    ehs = 1'b1; evs = 1'b1; ede = 1'b0; epx = 1'b0;
    if (tt >= 3) begin
      s = tt - 3;
      p = s % FT;
      h = p % HT;
      v = p / HT;
      ehs = !(h >= HV + HF && h < HV + HF + HS);
      evs = !(v >= VV + VF && v < VV + VF + VS);
      ede = (h < HV) && (v < VV);
      if (ede) begin
        a   = 12'((v / 10) * 80 + h / 8);
        g   = glyph(ram[a], v % 10);
        epx = g[7 - (h % 8)];
`ifdef CURSOR_EN
        blink = (s == 0) ? 0 : (s - 1) / FT;
        if (a == cursor_addr && ((blink / 16) % 2 == 1)) epx = ~epx;
`else
        blink = 0;
        if (blink != 0) epx = ~epx;
`endif
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  logic [7:0] seq_a5 = 8'hA5;
  logic       e_hs, e_vs, e_de, e_px;

  always @(negedge clk) begin
    if (started) begin
      exp_out(t, e_hs, e_vs, e_de, e_px);
      chk("read_addr",  32'(read_addr), 32'(exp_addr(t)));
      chk("frame_tick", 32'(frame_tick), 32'(t > 0 && (t % FT) == 0));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("de",    32'(de),    32'(e_de));
      chk("pixel", 32'(pixel), 32'(e_px));
      // Hand-computed anchors for the model itself.
      if (t >= 3 && t <= 10) begin
        chk("lit_pixel_a5", 32'(pixel), 32'(seq_a5[10 - t]));
        chk("lit_de_first", 32'(de), 32'd1);
      end
      if (t == 0) begin
        chk("lit_rst_hsync", 32'(hsync), 32'd1);
        chk("lit_rst_de",    32'(de),    32'd0);
      end
      if (mid_done) begin
        if (t == 391)  chk("lit_addr_h31_v9",  32'(read_addr), 32'd3);
        if (t == 400)  chk("lit_addr_h0_v10",  32'(read_addr), 32'd80);
        if (t == 791)  chk("lit_addr_last",    32'(read_addr), 32'd83);
        if (t == 35)   chk("lit_addr_hblank",  32'(read_addr), 32'd0);
        if (t == 850)  chk("lit_addr_vblank",  32'(read_addr), 32'd0);
        if (t == 960)  chk("lit_frame_tick",   32'(frame_tick), 32'd1);
        if (t == 37)   chk("lit_hsync_low",    32'(hsync), 32'd0);
`ifdef CURSOR_EN
        if (t == 20 * FT + 411) chk("lit_cursor_on",  32'(pixel), 32'd1);
        if (t == 5 * FT + 411)  chk("lit_cursor_off", 32'(pixel), 32'd0);
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom_range(0, 255));
    ram[0]  = 8'h1C;
    ram[81] = 8'h00;
    rst_n = 1'b0;
    cursor_addr = 12'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
    for (int i = 0; i < 2000 && t != 420; i++) @(negedge clk);
    if (t != 420) begin
      checks++;
      errors++;
      $display("FAIL mid_reset_wait: t=%0d, required 420", t);
    end
    rst_n = 1'b0;
    mid_done = 1'b1;
    $display("mid-frame reset at h=20 v=10");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (34 * FT + 20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    forever begin
      @(negedge clk);
`ifdef CURSOR_EN
      cursor_addr = 12'd81;
`else
      cursor_addr = 12'($urandom_range(0, 4095));
`endif
    end
  end

endmodule
